// File: rtl/prog_loader.sv
// Boot loader: takes a header/payload/checksum word stream from the host and writes
// the program image into the CPU's instruction and data memories. The CPU is enabled only if the checksum matches.
module prog_loader #(
  parameter int IMEM_WORDS = 128,
  parameter int DMEM_WORDS = 128
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  output logic [63:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [63:0] wdata_ext_2,
  output logic        enable,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [2:0]  dbg_state
);

  // Index counters must be able to reach the full capacity without wrapping.
  localparam int IW = $clog2(IMEM_WORDS + 1);
  localparam int DW = $clog2(DMEM_WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_IMEM, S_DLO, S_DHI, S_CHK, S_RUN, S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   ic_q, ic_d, dc_q, dc_d;
  logic [IW-1:0] iidx_q, iidx_d;
  logic [DW-1:0] didx_q, didx_d;
  logic [31:0]   lo_q, lo_d, csum_q, csum_d;
  logic          in_ready_q, in_ready_d, busy_q, busy_d;
  logic          enable_q, enable_d, done_q, done_d, error_q, error_d;
  logic          wen_q, wen_d, wen2_q, wen2_d;
  logic [63:0]   addr_q, addr_d, addr2_q, addr2_d, wdata2_q, wdata2_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          accept;

  // Handshake: a beat transfers on a rising edge where in_valid and in_ready are both high.
  // in_ready is a register decoded from the state, so it never depends on in_valid.
  assign accept = in_valid & in_ready_q;

  always_comb begin
    state_d  = state_q;
    ic_d     = ic_q;
    dc_d     = dc_q;
    iidx_d   = iidx_q;
    didx_d   = didx_q;
    lo_d     = lo_q;
    csum_d   = csum_q;
    wen_d    = 1'b0;
    wen2_d   = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    addr2_d  = addr2_q;
    wdata2_d = wdata2_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_HDR;
      S_HDR: begin
        if (accept) begin
          ic_d   = in_data[15:0];
          dc_d   = in_data[31:16];
          csum_d = in_data;
          iidx_d = '0;
          didx_d = '0;
          if (in_data[15:0] > 16'(IMEM_WORDS) || in_data[31:16] > 16'(DMEM_WORDS))
            state_d = S_ERR;
          else if (in_data[15:0] != 16'd0)
            state_d = S_IMEM;
          else if (in_data[31:16] != 16'd0)
            state_d = S_DLO;
          else
            state_d = S_CHK;
        end
      end
      S_IMEM: begin
        if (accept) begin
          wen_d   = 1'b1;
          addr_d  = 64'({iidx_q, 2'b00});
          wdata_d = in_data;
          csum_d  = csum_q ^ in_data;
          iidx_d  = iidx_q + IW'(1);
          if (16'(iidx_q) + 16'd1 == ic_q)
            state_d = (dc_q != 16'd0) ? S_DLO : S_CHK;
        end
      end
      S_DLO: begin
        if (accept) begin
          lo_d    = in_data;
          csum_d  = csum_q ^ in_data;
          state_d = S_DHI;
        end
      end
      S_DHI: begin
        if (accept) begin
          wen2_d   = 1'b1;
          addr2_d  = 64'({didx_q, 3'b000});
          wdata2_d = {in_data, lo_q};
          csum_d   = csum_q ^ in_data;
          didx_d   = didx_q + DW'(1);
          state_d  = (16'(didx_q) + 16'd1 == dc_q) ? S_CHK : S_DLO;
        end
      end
      S_CHK: begin
        if (accept) state_d = (in_data == csum_q) ? S_RUN : S_ERR;
      end
      S_RUN, S_ERR: begin
        if (start) begin
          state_d = S_HDR;
          ic_d    = '0;
          dc_d    = '0;
          iidx_d  = '0;
          didx_d  = '0;
          csum_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Status flags are decoded from the next state so they register alongside it.
    in_ready_d = (state_d == S_HDR) || (state_d == S_IMEM) || (state_d == S_DLO) ||
                 (state_d == S_DHI) || (state_d == S_CHK);
    busy_d     = in_ready_d;
    enable_d   = (state_d == S_RUN);
    done_d     = (state_d == S_RUN);
    error_d    = (state_d == S_ERR);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= S_IDLE;
      ic_q       <= '0;
      dc_q       <= '0;
      iidx_q     <= '0;
      didx_q     <= '0;
      lo_q       <= '0;
      csum_q     <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      enable_q   <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      wen_q      <= 1'b0;
      wen2_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      addr2_q    <= '0;
      wdata2_q   <= '0;
    end else begin
      state_q    <= state_d;
      ic_q       <= ic_d;
      dc_q       <= dc_d;
      iidx_q     <= iidx_d;
      didx_q     <= didx_d;
      lo_q       <= lo_d;
      csum_q     <= csum_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      enable_q   <= enable_d;
      done_q     <= done_d;
      error_q    <= error_d;
      wen_q      <= wen_d;
      wen2_q     <= wen2_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      addr2_q    <= addr2_d;
      wdata2_q   <= wdata2_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign addr_ext    = addr_q;
  assign wen_ext     = wen_q;
  assign ren_ext     = 1'b0;
  assign wdata_ext   = wdata_q;
  assign addr_ext_2  = addr2_q;
  assign wen_ext_2   = wen2_q;
  assign ren_ext_2   = 1'b0;
  assign wdata_ext_2 = wdata2_q;
  assign enable      = enable_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time loader sitting directly upstream of the `cpu` top. It accepts a 32-bit word stream from a host link over a valid/ready handshake, writes the program image through the CPU's external instruction-memory and data-memory ports, and checks an XOR checksum. On success it asserts the CPU `enable`; on any error it holds the CPU stopped.

## Interface
Parameters:
- `IMEM_WORDS`, 128: instruction-memory capacity in 32-bit words (512 B).
- `DMEM_WORDS`, 128: data-memory capacity in 64-bit words (1 KiB).

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk` in 1: main clock.
  - `arst_n` in 1: asynchronous active-low reset.
- Control:
  - `start` in 1: single-cycle load request.
- Host stream:
  - `in_valid` in 1: host stream word valid.
  - `in_data` in 32: host stream word.
  - `in_ready` out 1: loader can accept a word.
- Instruction-memory external port:
  - `addr_ext` out 64: byte address for instruction memory.
  - `wen_ext` out 1: instruction-memory write enable.
  - `ren_ext` out 1: instruction-memory read enable; constant 0.
  - `wdata_ext` out 32: instruction word.
- Data-memory external port:
  - `addr_ext_2` out 64: byte address for data memory.
  - `wen_ext_2` out 1: data-memory write enable.
  - `ren_ext_2` out 1: data-memory read enable; constant 0.
  - `wdata_ext_2` out 64: data word.
- Status:
  - `enable` out 1: CPU run enable.
  - `busy` out 1: load in progress.
  - `done` out 1: last load succeeded.
  - `error` out 1: last load failed.

## Operation
- Beat acceptance: a beat is accepted when `in_valid & in_ready`. `in_ready` is high only in HDR, IMEM, DLO, DHI and CHK. It never depends combinationally on `in_valid`.
- Stream format:
  - Header: `[15:0]`=ic (instruction count), `[31:16]`=dc (data count).
  - Then ic instruction words.
  - Then dc data words, each as two beats: low half, then high half.
  - Then one checksum beat.
- Checksum: XOR of the header and all payload beats. It excludes the checksum beat itself.
- FSM states and transitions:
  - IDLE: on `start`, go to HDR.
  - HDR: on accept, latch ic/dc and init checksum with the header word.
    - If ic>IMEM_WORDS or dc>DMEM_WORDS: go to ERR.
    - Else if ic≠0: go to IMEM.
    - Else if dc≠0: go to DLO.
    - Else: go to CHK.
  - IMEM: each accept writes `in_data` to byte address 4·i, for i=0..ic-1. After the ic-th accept, go to DLO if dc≠0, else CHK.
  - DLO: accept and hold the low half, then go to DHI.
  - DHI: accept the high half and write {high,low} to byte address 8·j. After the dc-th pair go to CHK, else go back to DLO.
  - CHK: on accept, compare the beat with the running XOR. Equal: go to RUN. Unequal: go to ERR.
  - RUN: `enable`=1 and `done`=1.
  - ERR: `error`=1 and `enable`=0.
- `start` in RUN or ERR: in the next cycle clear `enable`/`done`/`error`, reset the counters and enter HDR.
- `start` in HDR..CHK is ignored. `start` in IDLE enters HDR.
- `busy`=1 exactly in HDR, IMEM, DLO, DHI and CHK.
- Address arithmetic: 64-bit, zero-extended from the index counter. The index counters are wide enough to hold the value IMEM_WORDS or DMEM_WORDS without wrap.

## Timing
- Reset values: state IDLE. Every output is 0: `in_ready`, `addr_ext`, `wen_ext`, `wdata_ext`, `addr_ext_2`, `wen_ext_2`, `wdata_ext_2`, `enable`, `busy`, `done`, `error`. Checksum and counters are also 0.
- All outputs are registered.
- Write latency: a write pulse appears in the cycle after the accepting edge (1 cycle).
  - `wen_ext`/`wen_ext_2` are high for exactly one cycle per word.
  - addr and wdata are valid in that same cycle and hold until the next write.
- `in_ready` reflects the current state. Back-to-back accepts at one beat per cycle are supported.
- `in_valid` low stalls the FSM indefinitely, with no timeout. `in_ready` stays high while waiting.
- `enable` rises 1 cycle after the CHK accept edge, with `done` rising in the same cycle. This is after the final memory write pulse has completed.
- `wen_ext` and `wen_ext_2` are never high in the same cycle.
- Reset mid-load: outputs return to reset values immediately. Partially written memory is not cleared. A new `start` is required.
- Boundary: the final write goes to address 4·(IMEM_WORDS-1) or 8·(DMEM_WORDS-1). Counts equal to capacity are legal; counts equal to capacity+1 go to ERR.

## Test plan
- Nominal load:
  - Stimulus: `start`, header 0x0001_0002, instructions 0x00500093, 0x00108133, data 0x11223344 then 0x55667788, checksum = XOR of all five beats.
  - Response: `wen_ext` at addr 0 then 4; `wen_ext_2` at addr 0 with 0x55667788_11223344; `enable`=1 and `done`=1 one cycle after the checksum accept.
- Bad checksum: same stream with checksum ^1 -> `error`=1, `enable` stays 0, `in_ready`=0.
- Oversize header: header ic=129 -> ERR after the header; no write pulses.
- Empty image: header 0x0000_0000, checksum 0x0000_0000 -> RUN with zero writes.
- Stalls: `in_valid` toggled randomly during a 128-instruction / 128-data load -> write count and addresses exactly as listed; last writes at 0x1FC and 0x3F8.
- Reset and reload:
  - `arst_n` pulsed low during DHI -> all outputs return to 0.
  - `start` in RUN -> `enable` drops the next cycle and a fresh load completes.
